// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: memory handshake states, word type and
// the snooping bus controller state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    localparam int BLOCK_WORDS_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        DWB,
        SNOOP,
        C2C,
        MEMLD,
        UPGR
    } busctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first asserted request at or after ptr,
// wrapping by explicit compare so non-power-of-two N works.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          req [N],
    input  logic [PW-1:0] ptr,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = ptr;
        for (int k = 0; k < N; k++) begin
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
            idx = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// MSI snooping bus controller: arbitrates N icache/dcache pairs onto one
// memory port with cache-to-cache transfer and round-robin fairness.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CPUS        = 2,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
    parameter int CPUW        = $clog2(CPUS)
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN         [CPUS],
    input  word_t     iaddr        [CPUS],
    output logic      iwait        [CPUS],
    output word_t     iload        [CPUS],
    input  logic      dREN         [CPUS],
    input  logic      dWEN         [CPUS],
    input  word_t     daddr        [CPUS],
    input  word_t     dstore       [CPUS],
    input  logic      cctrans      [CPUS],
    input  logic      ccwrite      [CPUS],
    input  logic      ccflushed    [CPUS],
    output logic      dwait        [CPUS],
    output word_t     dload        [CPUS],
    output logic      ccwait       [CPUS],
    output logic      ccinv        [CPUS],
    output word_t     ccsnoopaddr  [CPUS],
    output logic      snoopy_write [CPUS],
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int                WCW       = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam word_t             BASE_MASK = ~word_t'(BLOCK_WORDS * 4 - 1);
    localparam logic [WCW-1:0]    LAST_WORD = WCW'(BLOCK_WORDS - 1);

    busctrl_state_t  state, next_state;
    logic [CPUW-1:0] req, sup, rr_d, rr_i;
    word_t           base;
    logic [WCW-1:0]  wcnt;
    logic            req_wr;

    logic            is_wb [CPUS];
    logic            is_miss [CPUS];
    logic            is_upg [CPUS];
    logic            dreq [CPUS];
    logic            d_gnt_valid, i_gnt_valid;
    logic [CPUW-1:0] d_gnt_idx, i_gnt_idx;
    logic            sup_found;
    logic [CPUW-1:0] sup_idx;
    logic            access, last_word;
    word_t           word_addr;

    assign access    = (ramstate == ACCESS);
    assign last_word = (wcnt == LAST_WORD);
    assign word_addr = base + (word_t'(wcnt) << 2);

    function automatic logic [CPUW-1:0] rr_next(input logic [CPUW-1:0] idx);
        return (idx == CPUW'(CPUS - 1)) ? '0 : idx + CPUW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < CPUS; i++) begin
            is_wb[i]   = dWEN[i] & ~cctrans[i];
            is_miss[i] = dREN[i] & cctrans[i];
            is_upg[i]  = cctrans[i] & ccwrite[i] & ~dREN[i] & ~dWEN[i];
            dreq[i]    = is_wb[i] | is_miss[i] | is_upg[i];
        end
    end

    rr_arbiter #(.N(CPUS), .PW(CPUW)) u_arb_d (
        .req       (dreq),
        .ptr       (rr_d),
        .gnt_valid (d_gnt_valid),
        .gnt_idx   (d_gnt_idx)
    );

    rr_arbiter #(.N(CPUS), .PW(CPUW)) u_arb_i (
        .req       (iREN),
        .ptr       (rr_i),
        .gnt_valid (i_gnt_valid),
        .gnt_idx   (i_gnt_idx)
    );

    // Descending scan so the lowest-index modified holder ends up as supplier.
    always_comb begin
        sup_found = 1'b0;
        sup_idx   = '0;
        for (int s = CPUS - 1; s >= 0; s--) begin
            if (s != int'(req) && !ccflushed[s] && dWEN[s]) begin
                sup_found = 1'b1;
                sup_idx   = CPUW'(s);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_gnt_valid) begin
                    if (is_wb[d_gnt_idx])        next_state = DWB;
                    else if (is_miss[d_gnt_idx]) next_state = SNOOP;
                    else                         next_state = UPGR;
                end else if (i_gnt_valid) begin
                    next_state = IFETCH;
                end
            end
            IFETCH:          if (access) next_state = IDLE;
            DWB, C2C, MEMLD: if (access && last_word) next_state = IDLE;
            SNOOP:           next_state = sup_found ? C2C : MEMLD;
            UPGR:            next_state = IDLE;
            default:         next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req    <= '0;
            sup    <= '0;
            rr_d   <= '0;
            rr_i   <= '0;
            base   <= '0;
            wcnt   <= '0;
            req_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wcnt <= '0;
                    if (d_gnt_valid) begin
                        req    <= d_gnt_idx;
                        base   <= daddr[d_gnt_idx] & BASE_MASK;
                        req_wr <= ccwrite[d_gnt_idx];
                    end else if (i_gnt_valid) begin
                        req <= i_gnt_idx;
                    end
                end
                IFETCH: if (access) rr_i <= rr_next(req);
                DWB, C2C, MEMLD: begin
                    if (access) begin
                        wcnt <= last_word ? '0 : wcnt + WCW'(1);
                        if (last_word) rr_d <= rr_next(req);
                    end
                end
                SNOOP: begin
                    sup  <= sup_idx;
                    wcnt <= '0;
                end
                UPGR:    rr_d <= rr_next(req);
                default: ;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        for (int i = 0; i < CPUS; i++) begin
            iwait[i]        = 1'b1;
            dwait[i]        = 1'b1;
            iload[i]        = '0;
            dload[i]        = '0;
            ccwait[i]       = 1'b0;
            ccinv[i]        = 1'b0;
            snoopy_write[i] = 1'b0;
            ccsnoopaddr[i]  = '0;
        end
        // Snoop signals persist from SNOOP until the transaction retires.
        if (state inside {SNOOP, C2C, MEMLD, UPGR}) begin
            for (int s = 0; s < CPUS; s++) begin
                if (s != int'(req) && !ccflushed[s]) begin
                    ccwait[s]       = 1'b1;
                    ccinv[s]        = req_wr;
                    snoopy_write[s] = req_wr;
                    ccsnoopaddr[s]  = base;
                end
            end
        end
        case (state)
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[req];
                if (access) begin
                    iwait[req] = 1'b0;
                    iload[req] = ramload;
                end
            end
            DWB: begin
                ramWEN   = 1'b1;
                ramaddr  = word_addr;
                ramstore = dstore[req];
                if (access) dwait[req] = 1'b0;
            end
            C2C: begin
                ramWEN     = 1'b1;
                ramaddr    = word_addr;
                ramstore   = dstore[sup];
                dload[req] = dstore[sup];
                if (access) begin
                    dwait[req] = 1'b0;
                    dwait[sup] = 1'b0;
                end
            end
            MEMLD: begin
                ramREN  = 1'b1;
                ramaddr = word_addr;
                if (access) begin
                    dwait[req] = 1'b0;
                    dload[req] = ramload;
                end
            end
            UPGR:    dwait[req] = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: directed scenarios plus random
// request mixes, checked against a transaction-level model of the bus rules.
module tb_coherence_bus_ctrl;
    import cpu_types_pkg::*;

    localparam int CPUS = 4;
    localparam int BW   = 2;
    localparam int NONE = 0, WB = 1, MISS = 2, UPG = 3, FETCH = 4;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN [CPUS];
    word_t     iaddr [CPUS];
    logic      iwait [CPUS];
    word_t     iload [CPUS];
    logic      dREN [CPUS];
    logic      dWEN [CPUS];
    word_t     daddr [CPUS];
    word_t     dstore [CPUS];
    logic      cctrans [CPUS];
    logic      ccwrite [CPUS];
    logic      ccflushed [CPUS];
    logic      dwait [CPUS];
    word_t     dload [CPUS];
    logic      ccwait [CPUS];
    logic      ccinv [CPUS];
    word_t     ccsnoopaddr [CPUS];
    logic      snoopy_write [CPUS];
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    coherence_bus_ctrl #(.CPUS(CPUS), .BLOCK_WORDS(BW)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccflushed(ccflushed),
        .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .snoopy_write(snoopy_write),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // Scenario description driven onto the ports, and model state.
    int        cls [CPUS];
    logic      fetch [CPUS];
    logic      holder [CPUS];
    logic      flushed [CPUS];
    logic      ccw [CPUS];
    word_t     ia [CPUS];
    word_t     da [CPUS];
    word_t     ds [CPUS];
    int        mrr_d, mrr_i;
    int        waitFix;
    ramstate_t waitKind;
    bit        fixedStore;
    int        errors, checks;

    logic            e_ren, e_wen;
    word_t           e_addr, e_store, e_base;
    logic [CPUS-1:0] e_dwait, e_iwait, e_cc, e_inv;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [CPUS-1:0] pk(input logic a [CPUS]);
        logic [CPUS-1:0] v;
        for (int i = 0; i < CPUS; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic ramstate_t rndWait();
        case ($urandom_range(0, 2))
            0:       return FREE;
            1:       return BUSY;
            default: return ERROR;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input bit idle);
        for (int i = 0; i < CPUS; i++) begin
            dWEN[i]      = (cls[i] == WB) || (holder[i] && !idle);
            dREN[i]      = (cls[i] == MISS);
            cctrans[i]   = (cls[i] == MISS) || (cls[i] == UPG);
            ccwrite[i]   = (cls[i] == UPG) || (cls[i] == MISS && ccw[i]);
            iREN[i]      = fetch[i];
            iaddr[i]     = ia[i];
            daddr[i]     = da[i];
            dstore[i]    = ds[i];
            ccflushed[i] = flushed[i];
        end
    endtask

    task automatic clearAll();
        for (int i = 0; i < CPUS; i++) begin
            cls[i] = NONE; fetch[i] = 1'b0; holder[i] = 1'b0;
            flushed[i] = 1'b0; ccw[i] = 1'b0;
            ia[i] = $urandom; da[i] = $urandom; ds[i] = $urandom;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".ramREN"}, 32'(ramREN), 32'(e_ren));
        checkOutput({tag, ".ramWEN"}, 32'(ramWEN), 32'(e_wen));
        if (e_ren || e_wen) checkOutput({tag, ".ramaddr"}, ramaddr, e_addr);
        if (e_wen) checkOutput({tag, ".ramstore"}, ramstore, e_store);
        checkOutput({tag, ".dwait"}, 32'(pk(dwait)), 32'(e_dwait));
        checkOutput({tag, ".iwait"}, 32'(pk(iwait)), 32'(e_iwait));
        checkOutput({tag, ".ccwait"}, 32'(pk(ccwait)), 32'(e_cc));
        checkOutput({tag, ".ccinv"}, 32'(pk(ccinv)), 32'(e_inv));
        checkOutput({tag, ".snoopy_write"}, 32'(pk(snoopy_write)), 32'(e_inv));
        for (int s = 0; s < CPUS; s++)
            checkOutput($sformatf("%s.ccsnoopaddr%0d", tag, s), ccsnoopaddr[s], e_cc[s] ? e_base : 32'h0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".iwait"}, 32'(pk(iwait)), 32'hF);
        checkOutput({tag, ".dwait"}, 32'(pk(dwait)), 32'hF);
        checkOutput({tag, ".ccwait"}, 32'(pk(ccwait)), 32'h0);
        checkOutput({tag, ".ccinv"}, 32'(pk(ccinv)), 32'h0);
        checkOutput({tag, ".snoopy_write"}, 32'(pk(snoopy_write)), 32'h0);
        checkOutput({tag, ".ramREN"}, 32'(ramREN), 32'h0);
        checkOutput({tag, ".ramWEN"}, 32'(ramWEN), 32'h0);
        checkOutput({tag, ".ramaddr"}, ramaddr, 32'h0);
        checkOutput({tag, ".ramstore"}, ramstore, 32'h0);
        for (int s = 0; s < CPUS; s++) begin
            checkOutput($sformatf("%s.ccsnoopaddr%0d", tag, s), ccsnoopaddr[s], 32'h0);
            checkOutput($sformatf("%s.dload%0d", tag, s), dload[s], 32'h0);
            checkOutput($sformatf("%s.iload%0d", tag, s), iload[s], 32'h0);
        end
    endtask

    // One complete bus transaction from the model's point of view; entered
    // and left with the controller idle.
    task automatic runTxn(input string tag);
        int w, c, sup, nwords, nw, idx, src;
        bit dataTx, invw, c2c, acc;
        logic [CPUS-1:0] others;
        w = -1; dataTx = 0; sup = -1;
        for (int k = 0; k < CPUS; k++) begin
            idx = (mrr_d + k) % CPUS;
            if (w < 0 && cls[idx] != NONE) begin w = idx; dataTx = 1; end
        end
        if (w < 0)
            for (int k = 0; k < CPUS; k++) begin
                idx = (mrr_i + k) % CPUS;
                if (w < 0 && fetch[idx]) w = idx;
            end
        if (w < 0) return;
        c      = dataTx ? cls[w] : FETCH;
        e_base = da[w] & ~32'(BW * 4 - 1);
        invw   = (c == UPG) || (c == MISS && ccw[w]);
        for (int s = 0; s < CPUS; s++) others[s] = (s != w) && !flushed[s];
        for (int s = CPUS - 1; s >= 0; s--)
            if (s != w && !flushed[s] && (cls[s] == WB || holder[s])) sup = s;
        c2c = (c == MISS) && (sup >= 0);

        e_ren = 0; e_wen = 0; e_dwait = '1; e_iwait = '1; e_cc = '0; e_inv = '0;
        ramstate = ramstate_t'($urandom_range(0, 3));
        applyStimulus(1);
        #1 checkAll({tag, ".idle"});
        tick();

        if (c == MISS || c == UPG) begin
            e_cc  = others;
            e_inv = others & {CPUS{invw}};
            ramstate = ramstate_t'($urandom_range(0, 3));
            applyStimulus(0);
            if (c == UPG) e_dwait[w] = 1'b0;
            #1 checkAll({tag, (c == UPG) ? ".upgr" : ".snoop"});
            tick();
            if (c == UPG) begin
                mrr_d = (w + 1) % CPUS;
                return;
            end
        end

        nwords = (c == FETCH) ? 1 : BW;
        src    = (c == WB) ? w : sup;
        for (int wd = 0; wd < nwords; wd++) begin
            nw = (waitFix >= 0) ? waitFix : $urandom_range(0, 2);
            if (c == WB || c2c) ds[src] = fixedStore ? 32'hAAAA0000 + 32'(wd) : $urandom;
            for (int t = 0; t <= nw; t++) begin
                acc      = (t == nw);
                ramstate = acc ? ACCESS : ((waitFix >= 0) ? waitKind : rndWait());
                ramload  = $urandom;
                applyStimulus(0);
                e_ren   = (c == FETCH) || (c == MISS && !c2c);
                e_wen   = (c == WB) || c2c;
                e_addr  = (c == FETCH) ? ia[w] : e_base + 32'(4 * wd);
                e_store = (src >= 0) ? ds[src] : 32'h0;
                e_dwait = '1;
                e_iwait = '1;
                if (acc) begin
                    if (c == FETCH) e_iwait[w] = 1'b0;
                    else            e_dwait[w] = 1'b0;
                    if (c2c) e_dwait[sup] = 1'b0;
                end
                #1 checkAll($sformatf("%s.w%0d.t%0d", tag, wd, t));
                if (acc && c == FETCH) checkOutput({tag, ".iload"}, iload[w], ramload);
                if (acc && c == MISS)  checkOutput($sformatf("%s.dload%0d", tag, wd), dload[w], c2c ? ds[sup] : ramload);
                tick();
            end
        end
        if (c == FETCH) mrr_i = (w + 1) % CPUS;
        else            mrr_d = (w + 1) % CPUS;
    endtask

    initial begin
        errors = 0; checks = 0;
        mrr_d = 0; mrr_i = 0;
        waitFix = -1; waitKind = BUSY; fixedStore = 0;
        RST = 1'b1; ramstate = FREE; ramload = '0;
        clearAll();
        applyStimulus(1);
        repeat (2) @(posedge CLK);
        #1 checkResetValues("reset");
        RST = 1'b0;

        // Every CPU fetching continuously: grants must rotate 0,1,2,3,0.
        for (int i = 0; i < CPUS; i++) fetch[i] = 1'b1;
        waitFix = 0;
        for (int n = 0; n < 5; n++) runTxn($sformatf("rot%0d", n));

        // CPU1 misses on a block CPU3 holds modified.
        clearAll();
        cls[1] = MISS; da[1] = 32'h208; holder[3] = 1'b1; fixedStore = 1;
        runTxn("c2c");
        fixedStore = 0;

        clearAll();
        cls[0] = UPG; da[0] = 32'h40; flushed[2] = 1'b1;
        runTxn("upg");

        // WB beats the fetch; slow memory; pointer then favours CPU1.
        clearAll();
        cls[0] = WB; da[0] = 32'h1000; fetch[1] = 1'b1;
        waitFix = 3; waitKind = BUSY;
        runTxn("wb_busy");
        cls[0] = NONE;
        runTxn("fetch_after_wb");
        fetch[1] = 1'b0; cls[0] = UPG; cls[1] = UPG; waitFix = 0;
        runTxn("rr_d_after_wb");

        clearAll();
        cls[2] = MISS; da[2] = 32'h5A0; waitFix = 2; waitKind = ERROR;
        runTxn("memld_err");

        waitFix = -1;
        for (int n = 0; n < 40; n++) begin
            clearAll();
            for (int i = 0; i < CPUS; i++) begin
                cls[i]     = $urandom_range(0, 5) % 4;
                fetch[i]   = 1'($urandom_range(0, 1));
                holder[i]  = ($urandom_range(0, 3) == 0);
                flushed[i] = ($urandom_range(0, 3) == 0);
                ccw[i]     = 1'($urandom_range(0, 1));
            end
            fetch[0] = 1'b1;
            runTxn($sformatf("rnd%0d", n));
        end

        // Abort in the middle of a cache-to-cache transfer.
        clearAll();
        cls[1] = MISS; da[1] = 32'h300; holder[3] = 1'b1;
        ramstate = BUSY;
        applyStimulus(1);
        tick();
        applyStimulus(0);
        tick();
        applyStimulus(0);
        #1 checkOutput("pre_rst.ramWEN", 32'(ramWEN), 32'h1);
        RST = 1'b1;
        #1 checkResetValues("rst_mid_c2c");
        tick();
        RST = 1'b0;
        mrr_d = 0; mrr_i = 0;
        clearAll();
        fetch[0] = 1'b1; ia[0] = 32'h100; waitFix = 0;
        runTxn("fetch_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
